// File: rtl/uart_rx_monitor_if.sv
// Serial line and decoded-byte signals of the UART receive monitor.
// master = monitor side, slave = environment/observer side.
interface uart_rx_monitor_if;
  logic        rxd;
  logic        txd;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_err;
  logic [15:0] rx_count;

  modport master (
    input  rxd,
    output txd, rx_data, rx_valid, frame_err, rx_count
  );

  modport slave (
    output rxd,
    input  txd, rx_data, rx_valid, frame_err, rx_count
  );
endinterface

// File: rtl/uart_rx_monitor.sv
// Receive-only 8N1 UART monitor: decodes bytes from rxd, pulses rx_valid/frame_err,
// counts good bytes and optionally echoes them to the simulator console.
module uart_rx_monitor #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned BAUD_RATE   = 115200,
  parameter bit          ECHO_EN     = 1'b1
) (
  input logic              clk_i,
  input logic              rst_n_i,
  uart_rx_monitor_if.master bus
);

  localparam int unsigned DIV  = CLK_FREQ_HZ / BAUD_RATE;
  localparam int unsigned TW   = $clog2(DIV);
  localparam int unsigned HALF = DIV / 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_e;

  state_e          state_q, state_d;
  logic            sync1_q, rxd_s_q;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            frame_err_q, frame_err_d;
  logic [15:0]     rx_count_q, rx_count_d;

  // Two-flop synchronizer; idles high so reset does not look like a start bit
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= 1'b1;
      rxd_s_q <= 1'b1;
    end else begin
      sync1_q <= bus.rxd;
      rxd_s_q <= sync1_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      rx_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      rx_count_q  <= rx_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q + TW'(1);
    bit_d       = bit_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    rx_count_d  = rx_count_q;

    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (!rxd_s_q) state_d = START;
      end
      // Re-check the line at mid start bit to reject glitches
      START: begin
        if (timer_q == TW'(HALF - 1)) begin
          timer_d = '0;
          bit_d   = '0;
          state_d = rxd_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (timer_q == TW'(DIV - 1)) begin
          timer_d = '0;
          shift_d = {rxd_s_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (timer_q == TW'(DIV - 1)) begin
          timer_d = '0;
          if (rxd_s_q) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            rx_count_d = rx_count_q + 16'd1;
            state_d    = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_IDLE;
          end
        end
      end
      // Break or bad stop: hold off until the line returns high
      WAIT_IDLE: begin
        timer_d = '0;
        if (rxd_s_q) state_d = IDLE;
      end
      default: begin
        timer_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign bus.txd       = 1'b1;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.rx_count  = rx_count_q;

`ifndef SYNTHESIS
  // Console echo of firmware output; newline byte ends the line
  if (ECHO_EN) begin : g_echo
    always @(posedge clk_i) begin
      if (rx_valid_q) begin
        if (rx_data_q == 8'h0A) $write("\n");
        else                    $write("%c", rx_data_q);
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Bench for uart_rx_monitor: directed scenarios plus random 8N1 traffic checked
// against a frame-level model (expected byte queue, running count, error count).
module tb_uart_rx_monitor;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned BAUD   = 100_000;
  localparam int unsigned DIV    = CLK_HZ / BAUD;

  logic clk_i   = 1'b0;
  logic rst_n_i = 1'b0;

  uart_rx_monitor_if bus ();

  uart_rx_monitor #(
    .CLK_FREQ_HZ (CLK_HZ),
    .BAUD_RATE   (BAUD),
    .ECHO_EN     (1'b1)
  ) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  logic [7:0]  exp_data_q[$];
  logic [15:0] exp_cnt_q[$];
  logic [15:0] exp_count = '0;
  logic [7:0]  exp_last  = '0;
  int          exp_ferr  = 0;

  // Observed pulses
  logic [7:0]  got_data_q[$];
  logic [15:0] got_cnt_q[$];
  int          got_ferr = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Each high cycle of a pulse is recorded, so a stretched pulse shows up as extras
  always @(negedge clk_i) begin
    if (rst_n_i) begin
      if (bus.rx_valid) begin
        got_data_q.push_back(bus.rx_data);
        got_cnt_q.push_back(bus.rx_count);
      end
      if (bus.frame_err) got_ferr++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic send_bit(input logic b);
    bus.rxd = b;
    cyc(DIV);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
    if (stop) begin
      exp_count = exp_count + 16'd1;
      exp_last  = d;
      exp_data_q.push_back(d);
      exp_cnt_q.push_back(exp_count);
    end else begin
      exp_ferr++;
    end
  endtask

  task automatic flush();
    exp_data_q.delete();
    exp_cnt_q.delete();
    got_data_q.delete();
    got_cnt_q.delete();
    exp_ferr = 0;
    got_ferr = 0;
  endtask

  task automatic check_rx(input string tag);
    int n;
    check($sformatf("%s_npulse", tag), 32'(got_data_q.size()), 32'(exp_data_q.size()));
    check($sformatf("%s_nferr", tag), 32'(got_ferr), 32'(exp_ferr));
    n = (got_data_q.size() < exp_data_q.size()) ? got_data_q.size() : exp_data_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_data%0d", tag, i), 32'(got_data_q[i]), 32'(exp_data_q[i]));
      check($sformatf("%s_cnt%0d", tag, i), 32'(got_cnt_q[i]), 32'(exp_cnt_q[i]));
    end
    check($sformatf("%s_rx_data", tag), 32'(bus.rx_data), 32'(exp_last));
    check($sformatf("%s_rx_count", tag), 32'(bus.rx_count), 32'(exp_count));
    flush();
  endtask

  initial begin
    logic [7:0] d;
    logic       stop;
    int         gap;

    bus.rxd = 1'b1;
    cyc(5);
    check("rst_rx_data", 32'(bus.rx_data), 32'h0);
    check("rst_rx_valid", 32'(bus.rx_valid), 32'h0);
    check("rst_frame_err", 32'(bus.frame_err), 32'h0);
    check("rst_rx_count", 32'(bus.rx_count), 32'h0);
    check("rst_txd", 32'(bus.txd), 32'h1);
    rst_n_i = 1'b1;
    cyc(2 * DIV);

    send_frame(8'h55, 1'b1);
    cyc(2 * DIV);
    check_rx("single");

    send_frame(8'h48, 1'b1);
    send_frame(8'h69, 1'b1);
    send_frame(8'h0A, 1'b1);
    cyc(2 * DIV);
    check_rx("b2b");

    bus.rxd = 1'b0;
    cyc(3);
    bus.rxd = 1'b1;
    cyc(3 * DIV);
    check_rx("glitch");

    send_frame(8'hA5, 1'b0);
    bus.rxd = 1'b1;
    cyc(3 * DIV);
    check_rx("ferr");
    send_frame(8'h31, 1'b1);
    cyc(2 * DIV);
    check_rx("after_ferr");

    // Break: line held low well past one frame gives a single error
    bus.rxd = 1'b0;
    cyc(30 * DIV);
    exp_ferr++;
    bus.rxd = 1'b1;
    cyc(3 * DIV);
    check_rx("break");

    // Reset in the middle of bit 4 of 0xFF
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    cyc(DIV / 2);
    rst_n_i = 1'b0;
    cyc(5);
    check("midrst_npulse", 32'(got_data_q.size()), 32'h0);
    check("midrst_nferr", 32'(got_ferr), 32'h0);
    flush();
    exp_count = '0;
    exp_last  = '0;
    rst_n_i = 1'b1;
    cyc(3 * DIV);
    check_rx("midrst");
    send_frame(8'h7E, 1'b1);
    cyc(2 * DIV);
    check_rx("after_rst");

    // Random traffic: printable bytes, occasional bad stop bits and glitches
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        bus.rxd = 1'b0;
        cyc(int'($urandom_range(1, 3)));
        bus.rxd = 1'b1;
        cyc(DIV + 5);
      end
      d    = ($urandom_range(0, 7) == 0) ? 8'h0A : 8'($urandom_range(8'h61, 8'h7A));
      stop = ($urandom_range(0, 6) != 0);
      send_frame(d, stop);
      bus.rxd = 1'b1;
      gap = int'($urandom_range(stop ? 0 : 2, 2 * DIV));
      cyc(gap);
    end
    cyc(3 * DIV);
    check_rx("random");

    $display("");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
